aes_ctr_round_ctrl: RTL

Sequencing controller for the AES-128 CTR engine. Drives key expansion (start pulse, round-key select) and the single-round encryption datapath, one round per cycle. Owns the 128-bit counter block and returns each finished keystream block over a valid/ready handshake. Sits between the AXI4-Lite register file and the key-expansion and round-datapath cores.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_ctr_inc.sv | 18 +
 rtl/aes_ctr_round_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 CTR sequencing logic.
// State encoding plus round count, block width and key-expansion wait.
package aes_pkg;

   localparam int AES_NR      = 10;
   localparam int AES_BLK_W   = 128;
   localparam int AES_KX_WAIT = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEXP,
      S_READY,
      S_ROUND,
      S_CAP,
      S_OUT
   } state_t;

endpackage

// File: rtl/aes_ctr_inc.sv
// Counter-block increment: low 32 bits wrap by default.
// AES_CTR_INC128_EN widens the increment to the full block.
module aes_ctr_inc
   import aes_pkg::*;
#(
   parameter int W = AES_BLK_W
) (
   input  logic [W-1:0] ctr,
   output logic [W-1:0] nxt
);

`ifdef AES_CTR_INC128_EN
   assign nxt = ctr + W'(1);
`else
   assign nxt = {ctr[W-1:32], ctr[31:0] + 32'd1};
`endif

endmodule

// File: rtl/aes_ctr_round_ctrl.sv
// AES-128 CTR sequencer: key expansion, one round per cycle, keystream out.
// Build option AES_CTR_INC128_EN selects a 128-bit counter increment.
module aes_ctr_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int CTR_W = AES_BLK_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_load,
   output logic             key_rdy,
   output logic             ke_start,
   input  logic             ke_ready,
   output logic [3:0]       ke_round,
   input  logic             ctr_load,
   input  logic [CTR_W-1:0] ctr_init,
   input  logic             blk_valid,
   output logic             blk_ready,
   output logic             rnd_en,
   output logic             rnd_first,
   output logic             rnd_last,
   output logic [3:0]       rnd_idx,
   output logic [CTR_W-1:0] ctr_blk,
   input  logic [127:0]     rd_state,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic [127:0]     ks_data
);

   localparam logic [3:0] NR_L   = 4'(NR);
   localparam logic [1:0] KX_END = 2'(AES_KX_WAIT);

   state_t           state;
   logic [1:0]       kx_cnt;
   logic [CTR_W-1:0] ctr;
   logic [CTR_W-1:0] ctr_src;
   logic [CTR_W-1:0] ctr_nxt;

   // A same-cycle ctr_load feeds the block directly, then gets incremented.
   assign ctr_src  = ctr_load ? ctr_init : ctr;
   assign ke_round = rnd_idx;

   aes_ctr_inc #(.W(CTR_W)) u_inc (
      .ctr (ctr_src),
      .nxt (ctr_nxt)
   );

   // Sequencer FSM with all handshake and round outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         kx_cnt    <= '0;
         ctr       <= '0;
         ctr_blk   <= '0;
         ks_data   <= '0;
         ks_valid  <= 1'b0;
         ke_start  <= 1'b0;
         key_rdy   <= 1'b1;
         blk_ready <= 1'b0;
         rnd_en    <= 1'b0;
         rnd_first <= 1'b0;
         rnd_last  <= 1'b0;
         rnd_idx   <= '0;
      end else begin
         ke_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (ctr_load) ctr <= ctr_init;
               if (key_load) begin
                  state    <= S_KEXP;
                  ke_start <= 1'b1;
                  kx_cnt   <= '0;
                  key_rdy  <= 1'b0;
               end
            end
            S_KEXP: begin
               if (kx_cnt != KX_END) begin
                  kx_cnt <= kx_cnt + 2'd1;
               end else if (ke_ready) begin
                  state     <= S_READY;
                  key_rdy   <= 1'b1;
                  blk_ready <= 1'b1;
               end
            end
            S_READY: begin
               if (key_load) begin
                  if (ctr_load) ctr <= ctr_init;
                  state     <= S_KEXP;
                  ke_start  <= 1'b1;
                  kx_cnt    <= '0;
                  key_rdy   <= 1'b0;
                  blk_ready <= 1'b0;
               end else if (blk_valid) begin
                  ctr_blk   <= ctr_src;
                  ctr       <= ctr_nxt;
                  state     <= S_ROUND;
                  rnd_idx   <= '0;
                  rnd_en    <= 1'b1;
                  rnd_first <= 1'b1;
                  rnd_last  <= (NR_L == 4'd0);
                  key_rdy   <= 1'b0;
                  blk_ready <= 1'b0;
               end else if (ctr_load) begin
                  ctr <= ctr_init;
               end
            end
            S_ROUND: begin
               if (rnd_last) begin
                  state    <= S_CAP;
                  rnd_en   <= 1'b0;
                  rnd_last <= 1'b0;
                  rnd_idx  <= '0;
               end else begin
                  rnd_idx   <= rnd_idx + 4'd1;
                  rnd_first <= 1'b0;
                  rnd_last  <= (rnd_idx + 4'd1 == NR_L);
               end
            end
            S_CAP: begin
               ks_data  <= rd_state;
               ks_valid <= 1'b1;
               state    <= S_OUT;
            end
            S_OUT: begin
               if (ks_ready) begin
                  ks_valid  <= 1'b0;
                  state     <= S_READY;
                  key_rdy   <= 1'b1;
                  blk_ready <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
